// File: rtl/p_addsub_pkg.sv
// Shared types and lane-mask helpers for the multi-cycle packed add/subtract unit.
package p_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int PW_2  = 1;
  localparam int PW_4  = 2;
  localparam int PW_8  = 3;
  localparam int PW_16 = 4;
  localparam int PW_32 = 5;
  localparam int PW_64 = 6;

  // Upper bound on W supported by the mask helpers; callers cast down to W.
  localparam int MAX_W = 1024;

  // Lane width in bits; out-of-range pw collapses to one full-width lane.
  function automatic int lane_width(input int pw, input int w);
    if (pw < 1 || pw > 30) return w;
    if ((1 << pw) > w) return w;
    return 1 << pw;
  endfunction

  function automatic logic [MAX_W-1:0] lane_lsb_mask(input int pw, input int w);
    logic [MAX_W-1:0] m;
    int lw;
    lw = lane_width(pw, w);
    for (int i = 0; i < MAX_W; i++) m[i] = (i < w) && ((i & (lw - 1)) == 0);
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] lane_msb_mask(input int pw, input int w);
    logic [MAX_W-1:0] m;
    int lw;
    lw = lane_width(pw, w);
    for (int i = 0; i < MAX_W; i++) m[i] = (i < w) && ((i & (lw - 1)) == (lw - 1));
    return m;
  endfunction

endpackage

// File: rtl/p_addsub_mc_if.sv
// Request/response handshake bundle for p_addsub_mc.
interface p_addsub_mc_if #(
  parameter int W   = 64,
  parameter int PWW = 3
);
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_lhs;
  logic [W-1:0]   req_rhs;
  logic [PWW-1:0] req_pw;
  logic           req_sub;
  logic           req_cin_en;
  logic           req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic [W-1:0]   rsp_lane_c;

  modport master (
    output req_valid, req_lhs, req_rhs, req_pw, req_sub, req_cin_en, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_lane_c
  );

  modport slave (
    input  req_valid, req_lhs, req_rhs, req_pw, req_sub, req_cin_en, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_lane_c
  );
endinterface

// File: rtl/p_addsub_slice.sv
// Combinational CHUNK-bit ripple adder whose carry chain restarts at every lane LSB.
module p_addsub_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [CHUNK-1:0] lsb,
  input  logic             lane_cin,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic [CHUNK-1:0] carry,
  output logic             cout
);

  logic c;
  logic ci;

  always_comb begin
    sum   = '0;
    carry = '0;
    c     = carry_in;
    ci    = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      ci       = lsb[i] ? lane_cin : c;
      sum[i]   = a[i] ^ b[i] ^ ci;
      c        = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
      carry[i] = c;
    end
  end

  assign cout = carry[CHUNK-1];

endmodule

// File: rtl/p_addsub_mc.sv
// Multi-cycle packed add/subtract: one CHUNK-bit slice per cycle, carry held between slices.
module p_addsub_mc
  import p_addsub_pkg::*;
#(
  parameter int W     = 64,
  parameter int CHUNK = 16,
  parameter int PWW   = $clog2($clog2(W) + 1)
) (
  input logic         g_clk,
  input logic         g_reset,
  p_addsub_mc_if.slave bus
);

  localparam int N  = W / CHUNK;
  localparam int CW = $clog2(N + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    lhs_q, rhs_q, lsb_q, msb_q, result_q, lane_c_q;
  logic            sub_q, cin_ovr_q, cin_q, carry_q, ready_q, valid_q;

  logic [W-1:0]     lsb_new, msb_new;
  logic             full_new;
  logic             lane_cin;
  logic [CHUNK-1:0] sum, bit_c;
  logic             cout;

  assign lsb_new  = W'(lane_lsb_mask(int'(bus.req_pw), W));
  assign msb_new  = W'(lane_msb_mask(int'(bus.req_pw), W));
  assign full_new = (lsb_new == W'(1));

  // The raw chain carry-in only ever lands on bit 0, i.e. the first slice.
  assign lane_cin = (cnt == '0 && cin_ovr_q) ? cin_q : sub_q;

  p_addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a        (lhs_q[CHUNK-1:0]),
    .b        (rhs_q[CHUNK-1:0]),
    .lsb      (lsb_q[CHUNK-1:0]),
    .lane_cin (lane_cin),
    .carry_in (carry_q),
    .sum      (sum),
    .carry    (bit_c),
    .cout     (cout)
  );

  // Operands and masks shift down each slice; results shift in from the top.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lhs_q     <= '0;
      rhs_q     <= '0;
      lsb_q     <= '0;
      msb_q     <= '0;
      result_q  <= '0;
      lane_c_q  <= '0;
      sub_q     <= 1'b0;
      cin_ovr_q <= 1'b0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ready_q && bus.req_valid) begin
            lhs_q     <= bus.req_lhs;
            rhs_q     <= bus.req_sub ? ~bus.req_rhs : bus.req_rhs;
            lsb_q     <= lsb_new;
            msb_q     <= msb_new;
            sub_q     <= bus.req_sub;
            cin_ovr_q <= bus.req_cin_en & full_new;
            cin_q     <= bus.req_cin;
            carry_q   <= 1'b0;
            cnt       <= '0;
            ready_q   <= 1'b0;
            state     <= BUSY;
          end else begin
            ready_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == CW'(N)) begin
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            lhs_q    <= lhs_q >> CHUNK;
            rhs_q    <= rhs_q >> CHUNK;
            lsb_q    <= lsb_q >> CHUNK;
            msb_q    <= msb_q >> CHUNK;
            result_q <= (result_q >> CHUNK) | (W'(sum) << (W - CHUNK));
            lane_c_q <= (lane_c_q >> CHUNK) | (W'(bit_c & msb_q[CHUNK-1:0]) << (W - CHUNK));
            carry_q  <= cout;
            cnt      <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_lane_c = lane_c_q;

endmodule
